// File: rtl/debug_dma_engine.sv
// -----------------------------------------------------------------------------
// debug_dma_engine
//
// Per-thread on-chip debug DMA controller placed between the host command
// interface and the IU ifetch stage.
//
// Every hardware thread owns one address register and one control register
// (buffer start, remaining count minus 1, and the cmd OP/NOP bit). The host
// writes them through the command interface. Each write carries an even parity
// bit and is dropped if the parity check fails.
//
// At ifetch the engine returns the fetching thread's DMA state through a
// two-stage pipeline. When the thread has a DMA in progress, the injected
// instruction comes from the DMA read buffer. Otherwise it is a SPARC NOP.
//
// At the end of xc/com the IU reports ack or done for the committing thread.
// The engine then advances that thread's address, buffer pointer and count,
// or terminates its DMA.
//
// Ports
//   gclk, rst           pipeline clock; synchronous active-high reset
//   cmd_*               command-interface register writes and parity bits
//   cmd_par_err         1-cycle pulse when a command write was dropped
//   fetch_tid/valid     thread fetching this cycle (stage F0)
//   rbuf_addr           read-buffer address, driven in stage F1
//   rbuf_inst           read-buffer data, returned one cycle after rbuf_addr
//   out_*               injected instruction and DMA state (stage F2)
//   in_*                commit feedback from the IU (tid, ack, done, state)
//   busy_vec            per-thread "DMA in progress" (cmd == OP)
// -----------------------------------------------------------------------------
module debug_dma_engine #(
  parameter int          NTHREAD   = 64,
  parameter int          DMABUFMSB = 9,
  parameter logic [31:0] NOPINST   = 32'h01000000,
  parameter int          TIDW      = $clog2(NTHREAD)
) (
  input  logic                 gclk,
  input  logic                 rst,
  // command interface
  input  logic [TIDW-1:0]      cmd_tid,
  input  logic [29:0]          cmd_addr,
  input  logic                 cmd_addr_par,
  input  logic                 cmd_addr_we,
  input  logic [DMABUFMSB:0]   cmd_buf_addr,
  input  logic [DMABUFMSB:0]   cmd_count,
  input  logic                 cmd_op,
  input  logic                 cmd_ctrl_par,
  input  logic                 cmd_ctrl_we,
  output logic                 cmd_par_err,
  // fetch side
  input  logic [TIDW-1:0]      fetch_tid,
  input  logic                 fetch_valid,
  output logic [DMABUFMSB:0]   rbuf_addr,
  input  logic [31:0]          rbuf_inst,
  output logic                 out_valid,
  output logic [31:0]          out_inst,
  output logic [29:0]          out_addr,
  output logic [31:0]          out_data,
  output logic [DMABUFMSB:0]   out_count,
  output logic [DMABUFMSB:0]   out_buf_addr,
  output logic                 out_cmd,
  // commit side
  input  logic [TIDW-1:0]      in_tid,
  input  logic                 in_ack,
  input  logic                 in_done,
  input  logic [29:0]          in_addr,
  input  logic [DMABUFMSB:0]   in_count,
  input  logic [DMABUFMSB:0]   in_buf_addr,
  output logic [NTHREAD-1:0]   busy_vec
);

  localparam int BW = DMABUFMSB + 1;

  // ---------------------------------------------------------------------------
  // Per-thread register file
  // ---------------------------------------------------------------------------
  // Reset must clear every thread at once, so the array is built from
  // flip-flops and not from block RAM.
  logic [29:0]        addr_reg [NTHREAD];
  logic [BW-1:0]      buf_reg  [NTHREAD];
  logic [BW-1:0]      cnt_reg  [NTHREAD];
  logic [NTHREAD-1:0] cmd_reg;            // 1 = dma_OP

  // Parity gating. A write is accepted only when the XOR of the covered data
  // bits equals the parity bit. The two registers are checked independently.
  logic addr_par_ok;
  logic ctrl_par_ok;
  logic addr_wr;
  logic ctrl_wr;

  assign addr_par_ok = ((^cmd_addr) == cmd_addr_par);
  assign ctrl_par_ok = ((^{cmd_buf_addr, cmd_count, cmd_op}) == cmd_ctrl_par);
  assign addr_wr     = cmd_addr_we && addr_par_ok;
  assign ctrl_wr     = cmd_ctrl_we && ctrl_par_ok;

  // Commit-side next values. The updated state is derived from the values the
  // pipeline returns, not from the stored registers.
  logic [29:0]   commit_addr_next;
  logic [BW-1:0] commit_buf_next;
  logic [BW-1:0] commit_cnt_next;
  logic          commit_last;
  logic          commit_adv;

  assign commit_addr_next = in_addr + 30'd1;
  assign commit_buf_next  = in_buf_addr + BW'(1);   // wraps at buffer end
  assign commit_last      = (in_count == '0);
  assign commit_cnt_next  = commit_last ? '0 : (in_count - BW'(1));
  assign commit_adv       = !in_done && in_ack && cmd_reg[in_tid];

  always_ff @(posedge gclk) begin
    if (rst) begin
      for (int i = 0; i < NTHREAD; i++) begin
        addr_reg[i] <= '0;
        buf_reg[i]  <= '0;
        cnt_reg[i]  <= '0;
      end
      cmd_reg <= '0;
    end else begin
      // The commit update is applied first. The command writes below come
      // later in the block, so for each register the command write takes
      // precedence whenever both target the same tid.
      if (in_done) begin
        cmd_reg[in_tid] <= 1'b0;
      end else if (commit_adv) begin
        addr_reg[in_tid] <= commit_addr_next;
        buf_reg[in_tid]  <= commit_buf_next;
        cnt_reg[in_tid]  <= commit_cnt_next;
        if (commit_last) begin
          cmd_reg[in_tid] <= 1'b0;
        end
      end

      if (addr_wr) begin
        addr_reg[cmd_tid] <= cmd_addr;
      end
      if (ctrl_wr) begin
        buf_reg[cmd_tid] <= cmd_buf_addr;
        cnt_reg[cmd_tid] <= cmd_count;
        cmd_reg[cmd_tid] <= cmd_op;
      end
    end
  end

  // Drop report: pulses on the cycle after the rejected write.
  logic par_err_reg;

  always_ff @(posedge gclk) begin
    if (rst) begin
      par_err_reg <= 1'b0;
    end else begin
      par_err_reg <= (cmd_addr_we && !addr_par_ok) ||
                     (cmd_ctrl_we && !ctrl_par_ok);
    end
  end

  assign cmd_par_err = par_err_reg;
  assign busy_vec    = cmd_reg;

  // ---------------------------------------------------------------------------
  // Fetch pipeline: F0 (read) -> F1 (rbuf address) -> F2 (output)
  // ---------------------------------------------------------------------------
  // F1 samples the register file at the same edge that commits any write, so
  // it sees the pre-write value. Only one instruction per thread is in flight,
  // so this stale value is never used in a way that matters.
  logic          f1_valid_reg;
  logic [29:0]   f1_addr_reg;
  logic [BW-1:0] f1_buf_reg;
  logic [BW-1:0] f1_cnt_reg;
  logic          f1_cmd_reg;

  always_ff @(posedge gclk) begin
    if (rst) begin
      f1_valid_reg <= 1'b0;
      f1_addr_reg  <= '0;
      f1_buf_reg   <= '0;
      f1_cnt_reg   <= '0;
      f1_cmd_reg   <= 1'b0;
    end else begin
      f1_valid_reg <= fetch_valid;
      f1_addr_reg  <= addr_reg[fetch_tid];
      f1_buf_reg   <= buf_reg[fetch_tid];
      f1_cnt_reg   <= cnt_reg[fetch_tid];
      f1_cmd_reg   <= cmd_reg[fetch_tid];
    end
  end

  assign rbuf_addr = f1_buf_reg;

  logic          f2_valid_reg;
  logic [29:0]   f2_addr_reg;
  logic [BW-1:0] f2_buf_reg;
  logic [BW-1:0] f2_cnt_reg;
  logic          f2_cmd_reg;

  always_ff @(posedge gclk) begin
    if (rst) begin
      f2_valid_reg <= 1'b0;
      f2_addr_reg  <= '0;
      f2_buf_reg   <= '0;
      f2_cnt_reg   <= '0;
      f2_cmd_reg   <= 1'b0;
    end else begin
      f2_valid_reg <= f1_valid_reg;
      f2_addr_reg  <= f1_addr_reg;
      f2_buf_reg   <= f1_buf_reg;
      f2_cnt_reg   <= f1_cnt_reg;
      f2_cmd_reg   <= f1_cmd_reg;
    end
  end

  // The read buffer has a registered output, so the word addressed in F1 is
  // already present on rbuf_inst in F2. It is muxed in here, not registered
  // again.
  assign out_valid    = f2_valid_reg;
  assign out_inst     = f2_cmd_reg ? rbuf_inst : NOPINST;
  assign out_addr     = f2_addr_reg;
  assign out_data     = '0;
  assign out_count    = f2_cnt_reg;
  assign out_buf_addr = f2_buf_reg;
  assign out_cmd      = f2_cmd_reg;

endmodule

// File: tb/tb_debug_dma_engine.sv
module tb_debug_dma_engine;

  localparam logic [31:0] NOP = 32'h01000000;

  logic        gclk;
  logic        rst;
  logic [5:0]  cmd_tid;
  logic [29:0] cmd_addr;
  logic        cmd_addr_par;
  logic        cmd_addr_we;
  logic [9:0]  cmd_buf_addr;
  logic [9:0]  cmd_count;
  logic        cmd_op;
  logic        cmd_ctrl_par;
  logic        cmd_ctrl_we;
  logic        cmd_par_err;
  logic [5:0]  fetch_tid;
  logic        fetch_valid;
  logic [9:0]  rbuf_addr;
  logic [31:0] rbuf_inst;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [29:0] out_addr;
  logic [31:0] out_data;
  logic [9:0]  out_count;
  logic [9:0]  out_buf_addr;
  logic        out_cmd;
  logic [5:0]  in_tid;
  logic        in_ack;
  logic        in_done;
  logic [29:0] in_addr;
  logic [9:0]  in_count;
  logic [9:0]  in_buf_addr;
  logic [63:0] busy_vec;

  debug_dma_engine dut (
    .gclk(gclk), .rst(rst),
    .cmd_tid(cmd_tid), .cmd_addr(cmd_addr), .cmd_addr_par(cmd_addr_par),
    .cmd_addr_we(cmd_addr_we), .cmd_buf_addr(cmd_buf_addr), .cmd_count(cmd_count),
    .cmd_op(cmd_op), .cmd_ctrl_par(cmd_ctrl_par), .cmd_ctrl_we(cmd_ctrl_we),
    .cmd_par_err(cmd_par_err),
    .fetch_tid(fetch_tid), .fetch_valid(fetch_valid),
    .rbuf_addr(rbuf_addr), .rbuf_inst(rbuf_inst),
    .out_valid(out_valid), .out_inst(out_inst), .out_addr(out_addr),
    .out_data(out_data), .out_count(out_count), .out_buf_addr(out_buf_addr),
    .out_cmd(out_cmd),
    .in_tid(in_tid), .in_ack(in_ack), .in_done(in_done), .in_addr(in_addr),
    .in_count(in_count), .in_buf_addr(in_buf_addr),
    .busy_vec(busy_vec)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // DMA read buffer with a registered read port
  logic [31:0] mem [1024];
  always @(posedge gclk) rbuf_inst <= mem[rbuf_addr];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: thread state plus the snapshots seen by the two fetch
  // stages (e1 = one edge after fetch, e2 = two edges after fetch).
  // ---------------------------------------------------------------------------
  logic [29:0] m_addr [64];
  logic [9:0]  m_buf  [64];
  logic [9:0]  m_cnt  [64];
  logic        m_cmd  [64];
  logic        e1_valid, e2_valid, e1_cmd, e2_cmd, e_err;
  logic [29:0] e1_addr, e2_addr;
  logic [9:0]  e1_buf, e2_buf, e1_cnt, e2_cnt;
  logic [63:0] e_busy;

  always @(posedge gclk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_addr[i] = '0; m_buf[i] = '0; m_cnt[i] = '0; m_cmd[i] = 1'b0;
      end
      e1_valid = 0; e1_cmd = 0; e1_addr = '0; e1_buf = '0; e1_cnt = '0;
      e2_valid = 0; e2_cmd = 0; e2_addr = '0; e2_buf = '0; e2_cnt = '0;
      e_err = 0;
    end else begin
      e2_valid = e1_valid; e2_cmd = e1_cmd; e2_addr = e1_addr;
      e2_buf = e1_buf; e2_cnt = e1_cnt;
      // fetch reads the state as it stood before this edge's writes
      e1_valid = fetch_valid; e1_cmd = m_cmd[fetch_tid]; e1_addr = m_addr[fetch_tid];
      e1_buf = m_buf[fetch_tid]; e1_cnt = m_cnt[fetch_tid];
      e_err = (cmd_addr_we && (^cmd_addr) != cmd_addr_par) ||
              (cmd_ctrl_we && (^{cmd_buf_addr, cmd_count, cmd_op}) != cmd_ctrl_par);
      if (in_done) m_cmd[in_tid] = 1'b0;
      else if (in_ack && m_cmd[in_tid]) begin
        m_addr[in_tid] = 30'((in_addr + 1) % (1 << 30));
        m_buf[in_tid]  = 10'((in_buf_addr + 1) % 1024);
        if (in_count == 0) begin m_cmd[in_tid] = 1'b0; m_cnt[in_tid] = '0; end
        else m_cnt[in_tid] = in_count - 1;
      end
      if (cmd_addr_we && (^cmd_addr) == cmd_addr_par) m_addr[cmd_tid] = cmd_addr;
      if (cmd_ctrl_we && (^{cmd_buf_addr, cmd_count, cmd_op}) == cmd_ctrl_par) begin
        m_buf[cmd_tid] = cmd_buf_addr; m_cnt[cmd_tid] = cmd_count; m_cmd[cmd_tid] = cmd_op;
      end
    end
    #1;
    for (int i = 0; i < 64; i++) e_busy[i] = m_cmd[i];
    chk("out_valid", 64'(out_valid), 64'(e2_valid));
    chk("out_inst", 64'(out_inst), 64'(e2_cmd ? mem[e2_buf] : NOP));
    chk("out_addr", 64'(out_addr), 64'(e2_addr));
    chk("out_count", 64'(out_count), 64'(e2_cnt));
    chk("out_buf_addr", 64'(out_buf_addr), 64'(e2_buf));
    chk("out_cmd", 64'(out_cmd), 64'(e2_cmd));
    chk("out_data", 64'(out_data), 64'd0);
    chk("rbuf_addr", 64'(rbuf_addr), 64'(e1_buf));
    chk("cmd_par_err", 64'(cmd_par_err), 64'(e_err));
    chk("busy_vec", busy_vec, e_busy);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change only just after the falling edge.
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(negedge gclk);
  endtask

  task automatic idle();
    cmd_addr_we = 0; cmd_ctrl_we = 0; in_ack = 0; in_done = 0; fetch_valid = 0;
  endtask

  task automatic wr_addr(input logic [5:0] t, input logic [29:0] a, input bit bad);
    cmd_tid = t; cmd_addr = a; cmd_addr_par = (^a) ^ bad; cmd_addr_we = 1;
  endtask

  task automatic wr_ctrl(input logic [5:0] t, input logic [9:0] b, input logic [9:0] c,
                         input logic op, input bit bad);
    cmd_tid = t; cmd_buf_addr = b; cmd_count = c; cmd_op = op;
    cmd_ctrl_par = (^{b, c, op}) ^ bad; cmd_ctrl_we = 1;
  endtask

  task automatic commit(input logic [5:0] t, input bit ack, input bit done,
                        input logic [29:0] a, input logic [9:0] b, input logic [9:0] c);
    in_tid = t; in_ack = ack; in_done = done; in_addr = a; in_buf_addr = b; in_count = c;
  endtask

  // issue a fetch and advance two edges so the F2 outputs belong to it
  task automatic fetch2(input logic [5:0] t);
    fetch_tid = t; fetch_valid = 1;
    cyc();
    fetch_valid = 0;
    cyc();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    rst = 1;
    cmd_tid = 0; cmd_addr = 0; cmd_addr_par = 0; cmd_buf_addr = 0; cmd_count = 0;
    cmd_op = 0; cmd_ctrl_par = 0; fetch_tid = 0;
    in_tid = 0; in_addr = 0; in_buf_addr = 0; in_count = 0;
    idle();
    cyc(); cyc();
    rst = 0;

    // post-reset fetch of an idle thread
    fetch_tid = 3; fetch_valid = 1; cyc(); fetch_valid = 0; cyc();
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_inst", 64'(out_inst), 64'h01000000);
    chk("t1_cmd", 64'(out_cmd), 64'd0);
    chk("t1_busy", busy_vec, 64'd0);

    // program tid 5 and fetch from it
    wr_addr(5, 30'h100, 0); wr_ctrl(5, 10'h3FE, 10'd2, 1, 0); cyc(); idle();
    fetch_tid = 5; fetch_valid = 1; cyc(); fetch_valid = 0;
    chk("t2_rbuf_addr", 64'(rbuf_addr), 64'h3FE);
    cyc();
    chk("t2_inst", 64'(out_inst), 64'(mem[10'h3FE]));
    chk("t2_addr", 64'(out_addr), 64'h100);
    chk("t2_busy5", 64'(busy_vec[5]), 64'd1);
    for (int k = 0; k < 3; k++) begin
      commit(5, 1, 0, 30'(32'h100 + k), 10'((32'h3FE + k) % 1024), 10'(2 - k));
      cyc();
    end
    idle();
    fetch2(5);
    chk("t2_end_addr", 64'(out_addr), 64'h103);
    chk("t2_end_buf", 64'(out_buf_addr), 64'h001);
    chk("t2_end_count", 64'(out_count), 64'd0);
    chk("t2_end_cmd", 64'(out_cmd), 64'd0);
    chk("t2_end_busy5", 64'(busy_vec[5]), 64'd0);

    // control write with a bad parity bit is dropped
    wr_ctrl(5, 10'h55, 10'd3, 1, 1); cyc(); idle();
    chk("t3_err_pulse", 64'(cmd_par_err), 64'd1);
    cyc();
    chk("t3_err_clear", 64'(cmd_par_err), 64'd0);
    chk("t3_busy", busy_vec, 64'd0);
    fetch2(5);
    chk("t3_buf_kept", 64'(out_buf_addr), 64'h001);

    // done aborts a running transfer
    wr_ctrl(5, 10'h20, 10'd7, 1, 0); cyc(); idle();
    commit(5, 1, 1, 30'h5, 10'h20, 10'd7); cyc(); idle();
    fetch2(5);
    chk("t4_inst", 64'(out_inst), 64'h01000000);
    chk("t4_cmd", 64'(out_cmd), 64'd0);
    chk("t4_count", 64'(out_count), 64'd7);

    // commit and control write to the same tid: control write wins
    wr_ctrl(9, 10'h40, 10'd3, 1, 0); cyc(); idle();
    commit(9, 1, 0, 30'h0, 10'h40, 10'd5); wr_ctrl(9, 10'h40, 10'h10, 1, 0); cyc(); idle();
    fetch2(9);
    chk("t5_count", 64'(out_count), 64'h10);
    chk("t5_cmd", 64'(out_cmd), 64'd1);
    chk("t5_addr", 64'(out_addr), 64'd1);

    // ack on an idle thread changes nothing
    wr_addr(20, 30'h1234, 0); cyc(); idle();
    commit(20, 1, 0, 30'h777, 10'h5, 10'd4); cyc(); idle();
    fetch2(20);
    chk("t6_addr", 64'(out_addr), 64'h1234);
    chk("t6_count", 64'(out_count), 64'd0);

    // address wraps to 0 at the top of the 30-bit range
    wr_addr(7, 30'h3FFFFFFF, 0); wr_ctrl(7, 10'h10, 10'd3, 1, 0); cyc(); idle();
    commit(7, 1, 0, 30'h3FFFFFFF, 10'h3FF, 10'd3); cyc(); idle();
    fetch2(7);
    chk("t6_wrap_addr", 64'(out_addr), 64'd0);
    chk("t6_wrap_buf", 64'(out_buf_addr), 64'd0);
    chk("t6_wrap_count", 64'(out_count), 64'd2);

    // reset while DMAs are active aborts every thread
    rst = 1; cyc(); rst = 0;
    chk("t7_busy", busy_vec, 64'd0);

    // randomized traffic on a small set of threads
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      cmd_addr_we = 0; cmd_ctrl_we = 0;
      if ($urandom_range(0, 4) == 0)
        wr_addr(6'($urandom_range(0, 7)), 30'($urandom), $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0)
        wr_ctrl(6'($urandom_range(0, 7)), 10'($urandom), 10'($urandom_range(0, 4)),
                1'($urandom_range(0, 9) < 7), $urandom_range(0, 7) == 0);
      commit(6'($urandom_range(0, 7)), $urandom_range(0, 9) < 4, $urandom_range(0, 19) == 0,
             ($urandom_range(0, 7) == 0) ? 30'h3FFFFFFF : 30'($urandom),
             10'($urandom), 10'($urandom_range(0, 3)));
      fetch_tid = 6'($urandom_range(0, 7));
      fetch_valid = ($urandom_range(0, 9) < 7);
      cyc();
    end
    rst = 0; idle();
    cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debug_dma_engine.md
Name: debug_dma_engine

Overview:
- Per-thread on-chip debug DMA controller sitting between the host command interface and the IU ifetch stage.
- Holds one address register and one control register per hardware thread, written through the command interface.
- At ifetch it injects LD/ST instructions from the DMA read buffer, together with the DMA pipeline state, for the fetching thread.
- At the end of xc/com it consumes the IU's ack/done feedback and advances the per-thread address, buffer pointer and count.

Parameters:
- NTHREAD, 64, number of hardware threads; thread ID width TIDW = log2(NTHREAD).
- DMABUFMSB, 9, MSB of buffer address and count fields (1024-entry buffer).
- NOPINST, 32'h01000000, SPARC NOP emitted when no DMA is active.

Ports:
- gclk  in  1  pipeline clock.
- rst  in  1  synchronous active-high reset.
- cmd_tid  in  TIDW  thread targeted by a command-interface write.
- cmd_addr  in  30  word-aligned virtual address for the address register.
- cmd_addr_par  in  1  even parity of cmd_addr.
- cmd_addr_we  in  1  address register write enable.
- cmd_buf_addr  in  DMABUFMSB+1  control register: buffer start.
- cmd_count  in  DMABUFMSB+1  control register: words remaining minus 1.
- cmd_op  in  1  control register: 1=dma_OP, 0=dma_NOP.
- cmd_ctrl_par  in  1  even parity over {cmd_buf_addr, cmd_count, cmd_op}.
- cmd_ctrl_we  in  1  control register write enable.
- cmd_par_err  out  1  1-cycle pulse when a command write is dropped for parity error.
- fetch_tid  in  TIDW  thread fetching this cycle.
- fetch_valid  in  1  fetch slot valid.
- rbuf_addr  out  DMABUFMSB+1  read-buffer address.
- rbuf_inst  in  32  read-buffer instruction, arrives 1 cycle after rbuf_addr.
- out_valid  out  1  injection output valid.
- out_inst  out  32  injected instruction.
- out_addr  out  30  state.addr.
- out_data  out  32  state.data, always 0.
- out_count  out  DMABUFMSB+1  state.count.
- out_buf_addr  out  DMABUFMSB+1  state.buf_addr.
- out_cmd  out  1  state.cmd.
- in_tid  in  TIDW  committing thread.
- in_ack  in  1  DMA word accomplished; advance counters.
- in_done  in  1  abort/finish: force cmd to NOP.
- in_addr, in_count, in_buf_addr  in  30/DMABUFMSB+1/DMABUFMSB+1  state returned from the pipeline.
- busy_vec  out  NTHREAD  per-thread cmd==dma_OP.

Behaviour:
- Reset (synchronous, rst=1 at a gclk edge):
  - All per-thread registers go to 0 with cmd=NOP.
  - Outputs after the reset edge: out_valid=0, out_inst=NOPINST, other out_* = 0, cmd_par_err=0, busy_vec=0.
  - rst asserted mid-DMA aborts every thread; in-flight fetch pipeline stages are cleared.
- Command write:
  - A write is accepted only if the parity check passes: XOR of the covered data bits == par bit.
  - On mismatch the register is unchanged and cmd_par_err pulses the next cycle.
  - Address and control writes to the same tid in the same cycle are independent; each is checked separately, and either mismatch raises the error pulse.
- Fetch pipeline, latency 2:
  - Stage F0: fetch_tid indexes the register array; read data is registered into F1.
  - Stage F1: rbuf_addr = F1.buf_addr, driven combinationally from the F1 register.
  - Stage F2 (registered): out_valid = F1 valid.
    - If cmd=OP: out_inst = rbuf_inst.
    - If cmd=NOP: out_inst = NOPINST.
  - State fields pass through unchanged.
- Commit update, applied at the gclk edge for in_tid:
  - If in_done: cmd <= NOP.
  - Else if in_ack and cmd==OP:
    - addr <= in_addr+1, wraps mod 2^30.
    - buf_addr <= in_buf_addr+1, wraps 1023->0.
    - If in_count==0: cmd <= NOP and count <= 0. Otherwise count <= in_count-1.
  - in_ack with cmd==NOP: ignored.
- Collision rules:
  - Command write and commit update to the same tid in the same cycle: the command write wins per register.
  - A control write from the command interface may also set cmd=OP.
- Read during write: an F0 read of a tid being written in the same cycle returns the pre-write value. The fine-grained single-instruction-per-thread pipeline guarantees no hazard.
- busy_vec reflects the register state one cycle after any write.

Test Plan:
- Reset with rst=1 for 2 cycles, then fetch tid 3 -> out_valid=1 at +2 cycles, out_inst=32'h01000000, out_cmd=0, busy_vec=0.
- Program tid 5 with addr=0x100, buf_addr=0x3FE, count=2, op=1, correct parity; fetch tid 5 -> rbuf_addr=0x3FE at +1, out_inst equals the buffer word at +2. Three acks -> buf_addr sequence 0x3FE, 0x3FF, 0x000, addr 0x101..0x103. Third ack clears cmd; busy_vec[5]=0.
- Control write with flipped cmd_ctrl_par -> cmd_par_err=1 for exactly one cycle; tid state unchanged; busy_vec unchanged.
- in_done on tid 5 mid-transfer (count=7) -> cmd=NOP; the next fetch emits NOPINST.
- Same-cycle commit ack and cmd_ctrl_we to tid 9 with count=0x10 -> count reads 0x10 and cmd=OP (command wins).
- in_ack on a NOP thread -> no register change; addr=0x3FFFFFFF with ack -> wraps to 0.
